// File: rtl/iir_feeder_if.sv
// Handshake and configuration bundle between a host/IIR environment and iir_feeder.
// The ovf signal exists only when IIR_FEEDER_OVF_EN is defined.
interface iir_feeder_if;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        go;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_full;
  logic [3:0]  s_count;
  logic        iir_ready;
  logic        iir_done;
  logic        iir_start;
  logic [15:0] params;
  logic        start;
  logic [7:0]  din;
  logic        busy;
  logic [15:0] issued;
`ifdef IIR_FEEDER_OVF_EN
  logic        ovf;
`endif

  modport master (
`ifdef IIR_FEEDER_OVF_EN
    input  ovf,
`endif
    output cfg_we, cfg_addr, cfg_data, go, s_valid, s_data, iir_ready, iir_done,
    input  s_full, s_count, iir_start, params, start, din, busy, issued
  );

  modport slave (
`ifdef IIR_FEEDER_OVF_EN
    output ovf,
`endif
    input  cfg_we, cfg_addr, cfg_data, go, s_valid, s_data, iir_ready, iir_done,
    output s_full, s_count, iir_start, params, start, din, busy, issued
  );
endinterface

// File: rtl/iir_feeder.sv
// Sample FIFO plus coefficient loader that sequences a downstream IIR filter.
// Optional sticky overflow flag enabled by defining IIR_FEEDER_OVF_EN.
//
// state    | meaning
// IDLE     | coefficients writable, params shows a1, waits for go
// PARAM    | streams coef[0..4] on params, iir_start with k=0
// WAIT_RDY | waits for iir_ready with a non-empty FIFO
// ISSUE    | one-cycle start strobe, FIFO head on din, pop
// WAIT_ACK | waits for iir_ready low before re-arming
module iir_feeder (
  input  logic clk,
  input  logic reset,
  iir_feeder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PARAM, WAIT_RDY, ISSUE, WAIT_ACK} state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [15:0] coef_q [5];
  logic [15:0] coef_d [5];
  logic [7:0]  mem_q [8];
  logic [2:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] params_q, params_d;
  logic [7:0]  din_q, din_d;
  logic        start_q, start_d;
  logic        iir_start_q, iir_start_d;
  logic        busy_q, busy_d;
  logic [15:0] issued_q, issued_d;
  logic        full, push, pop;

  assign full = (count_q == 4'd8);
  assign push = bus.s_valid && !full;
  assign pop  = (state_q == ISSUE);

  always_comb begin
    coef_d = coef_q;
    if (bus.cfg_we && state_q == IDLE && bus.cfg_addr <= 3'd4)
      coef_d[bus.cfg_addr] = bus.cfg_data;

    wptr_d   = push ? wptr_q + 3'd1 : wptr_q;
    rptr_d   = pop  ? rptr_q + 3'd1 : rptr_q;
    count_d  = count_q + {3'b000, push} - {3'b000, pop};
    issued_d = pop ? issued_q + 16'd1 : issued_q;

    state_d     = state_q;
    k_d         = k_q;
    params_d    = params_q;
    din_d       = din_q;
    start_d     = 1'b0;
    iir_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        params_d = coef_d[0];
        if (bus.go) begin
          state_d     = PARAM;
          k_d         = 3'd0;
          issued_d    = 16'd0;
          iir_start_d = 1'b1;
        end
      end
      PARAM: begin
        if (k_q == 3'd4) begin
          state_d = WAIT_RDY;
        end else begin
          k_d      = k_q + 3'd1;
          params_d = coef_q[k_q + 3'd1];
        end
      end
      WAIT_RDY: begin
        if (bus.iir_ready && count_q != 4'd0) begin
          state_d = ISSUE;
          start_d = 1'b1;
          din_d   = mem_q[rptr_q];
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        // The IIR drops ready one cycle late; only a sampled low re-arms us.
        if (!bus.iir_ready) state_d = WAIT_RDY;
      end
      default: state_d = IDLE;
    endcase

    // Done aborts any session; an in-flight ISSUE still pops via pop above.
    if (state_q != IDLE && bus.iir_done) begin
      state_d     = IDLE;
      k_d         = 3'd0;
      params_d    = coef_q[0];
      din_d       = din_q;
      start_d     = 1'b0;
      iir_start_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      for (int i = 0; i < 5; i++) coef_q[i] <= 16'd0;
      wptr_q      <= 3'd0;
      rptr_q      <= 3'd0;
      count_q     <= 4'd0;
      params_q    <= 16'd0;
      din_q       <= 8'd0;
      start_q     <= 1'b0;
      iir_start_q <= 1'b0;
      busy_q      <= 1'b0;
      issued_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      coef_q      <= coef_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      params_q    <= params_d;
      din_q       <= din_d;
      start_q     <= start_d;
      iir_start_q <= iir_start_d;
      busy_q      <= busy_d;
      issued_q    <= issued_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.s_data;
  end

`ifdef IIR_FEEDER_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else if (bus.s_valid && full) ovf_q <= 1'b1;
  end
  assign bus.ovf = ovf_q;
`endif

  assign bus.s_full    = full;
  assign bus.s_count   = count_q;
  assign bus.params    = params_q;
  assign bus.din       = din_q;
  assign bus.start     = start_q;
  assign bus.iir_start = iir_start_q;
  assign bus.busy      = busy_q;
  assign bus.issued    = issued_q;

endmodule

// File: tb/tb_iir_feeder.sv
// Directed plus randomized bench for iir_feeder with a queue-based reference model.
module tb_iir_feeder;
  logic clk = 1'b0;
  logic reset;
  iir_feeder_if bus();

  iir_feeder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_coef [5];
  logic [7:0]  mq [$];
  int          mode;      // 0 waiting for ready, 1 issuing, 2 waiting for ready low
  logic [7:0]  m_din;
  logic [15:0] m_issued;
  bit          m_ovf;
  bit          m_idle;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(string tag);
    logic [7:0] d;
    bit push_ok, drop;
    int nmode;
    d       = bus.s_data;
    push_ok = bus.s_valid && (mq.size() < 8);
    drop    = bus.s_valid && (mq.size() >= 8);
    nmode   = mode;
    case (mode)
      0: if (bus.iir_ready && mq.size() > 0) begin nmode = 1; m_din = mq[0]; end
      1: nmode = 2;
      default: if (!bus.iir_ready) nmode = 0;
    endcase
    tick();
    if (mode == 1) begin void'(mq.pop_front()); m_issued++; end
    if (push_ok) mq.push_back(d);
    if (drop) m_ovf = 1'b1;
    mode = nmode;
    chk({tag, ".start"}, bus.start, (mode == 1));
    chk({tag, ".din"}, bus.din, m_din);
    chk({tag, ".count"}, bus.s_count, mq.size());
    chk({tag, ".full"}, bus.s_full, (mq.size() == 8));
    chk({tag, ".issued"}, bus.issued, m_issued);
    chk({tag, ".busy"}, bus.busy, 1'b1);
  endtask

  task automatic cfg_write(logic [2:0] addr, logic [15:0] data);
    bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_data = data;
    tick();
    bus.cfg_we = 1'b0;
    if (m_idle && addr < 5) m_coef[addr] = data;
  endtask

  task automatic start_session(string tag);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    m_idle = 1'b0;
    m_issued = 16'd0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk({tag, ".params"}, bus.params, m_coef[k]);
      chk({tag, ".iir_start"}, bus.iir_start, (k == 0));
    end
    tick();
    mode = 0;
    chk({tag, ".iir_start_end"}, bus.iir_start, 1'b0);
    chk({tag, ".busy"}, bus.busy, 1'b1);
    chk({tag, ".issued"}, bus.issued, 16'd0);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, ".count"}, bus.s_count, 4'd0);
    chk({tag, ".full"}, bus.s_full, 1'b0);
    chk({tag, ".params"}, bus.params, 16'd0);
    chk({tag, ".din"}, bus.din, 8'd0);
    chk({tag, ".start"}, bus.start, 1'b0);
    chk({tag, ".iir_start"}, bus.iir_start, 1'b0);
    chk({tag, ".busy"}, bus.busy, 1'b0);
    chk({tag, ".issued"}, bus.issued, 16'd0);
`ifdef IIR_FEEDER_OVF_EN
    chk({tag, ".ovf"}, bus.ovf, 1'b0);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_coef[i] = 16'd0;
    mq.delete();
    mode = 0; m_din = 8'd0; m_issued = 16'd0; m_ovf = 1'b0; m_idle = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] vals [3];
    int pre;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0; bus.go = 0;
    bus.s_valid = 0; bus.s_data = 0; bus.iir_ready = 0; bus.iir_done = 0;
    model_reset();
    reset = 1'b1;
    #12;
    check_reset_values("reset");
    @(negedge clk) reset = 1'b0;
    tick();

    // coefficient load and PARAM streaming
    for (int i = 0; i < 5; i++) begin
      cfg_write(3'(i), 16'((i + 1) * 16'h0100));
      if (i == 0) chk("idle_params_a1", bus.params, 16'h0100);
    end
    cfg_write(3'd5, 16'hFFFF);
    chk("idle_params_after_idx5", bus.params, 16'h0100);
    start_session("req19");
    cfg_write(3'd0, 16'hDEAD);   // dropped: not in IDLE

    // three samples with ready held high: exactly one issue until ready drops
    bus.iir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1; bus.s_data = vals[i];
      step("req20_push");
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("req20_hold");
    for (int r = 0; r < 3; r++) begin
      bus.iir_ready = 1'b0; step("req20_low");
      bus.iir_ready = 1'b1; step("req20_high");
      step("req20_issue"); step("req20_ack");
    end
    chk("req20_issued", bus.issued, 16'd3);
    chk("req20_last_din", bus.din, 8'h33);

    // overfill
    bus.iir_ready = 1'b0;
    step("req21_settle");
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 8'($urandom);
      step("req21_push");
    end
    bus.s_valid = 1'b0;
    chk("req21_count", bus.s_count, 4'd8);
    chk("req21_full", bus.s_full, 1'b1);
`ifdef IIR_FEEDER_OVF_EN
    chk("req21_ovf", bus.ovf, 1'b1);
`endif

    // push while full in the same cycle as a pop
    bus.iir_ready = 1'b1;
    step("req22_arm");
    bus.s_valid = 1'b1; bus.s_data = 8'hEE;
    step("req22_pushpop");
    chk("req22_count", bus.s_count, 4'd7);
    bus.s_valid = 1'b0;

    for (int i = 0; i < 100 && mq.size() > 0; i++) begin
      bus.iir_ready = ~bus.iir_ready;
      step("drain");
    end
    chk("drain_empty", bus.s_count, 4'd0);

    for (int i = 0; i < 300; i++) begin
      bus.s_valid   = 1'($urandom_range(0, 1));
      bus.s_data    = 8'($urandom);
      bus.iir_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // done while in WAIT_ACK
    bus.s_valid = 1'b1; bus.s_data = 8'($urandom); bus.iir_ready = 1'b1;
    step("req23_push");
    bus.s_valid = 1'b0;
    for (int i = 0; i < 20 && mode != 2; i++) step("req23_seek");
    chk("req23_in_wait_ack", mode, 2);
    bus.iir_done = 1'b1;
    tick();
    bus.iir_done = 1'b0;
    m_idle = 1'b1; mode = 0;
    chk("req23_busy", bus.busy, 1'b0);
    chk("req23_params_a1", bus.params, 16'h0100);
    for (int i = 0; i < 5; i++) cfg_write(3'(i), 16'($urandom));
    start_session("req23_newcoef");

    // done during ISSUE with go held high
    bus.iir_ready = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'h5A;
    step("req12_push");
    bus.s_valid = 1'b0;
    for (int i = 0; i < 20 && mode != 1; i++) step("req12_seek");
    chk("req12_in_issue", mode, 1);
    pre = mq.size();
    bus.iir_done = 1'b1; bus.go = 1'b1;
    tick();
    bus.iir_done = 1'b0;
    void'(mq.pop_front()); m_issued++;
    chk("req12_busy", bus.busy, 1'b0);
    chk("req12_popped", bus.s_count, pre - 1);
    chk("req12_issued", bus.issued, m_issued);
    tick();
    bus.go = 1'b0;
    chk("req13_restart", bus.iir_start, 1'b1);
    chk("req13_busy", bus.busy, 1'b1);
    chk("req13_issued", bus.issued, 16'd0);
    chk("req13_params", bus.params, m_coef[0]);

    // reset during PARAM at k=2
    bus.iir_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.iir_done = 1'b1;
    tick();
    bus.iir_done = 1'b0;
    chk("req24_idle", bus.busy, 1'b0);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick(); tick();
    chk("req24_k2", bus.params, m_coef[2]);
    #2 reset = 1'b1;
    #1;
    check_reset_values("req24_async");
    @(negedge clk) reset = 1'b0;
    model_reset();
    tick();
    check_reset_values("req24_after");
    start_session("req24_zero_coefs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iir_feeder.md
IIR_FEEDER -- requirements
Module: iir_feeder

Interface
REQ-001 SHALL provide the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  3  coefficient index: 0=a1, 1=a2, 2=b0, 3=b1, 4=b2; indices 5-7 ignored
- cfg_data  in  16  coefficient value
- go  in  1  level; starts a filter session from IDLE
- s_valid  in  1  sample push request
- s_data  in  8  sample value
- s_full  out  1  FIFO holds 8 entries
- s_count  out  4  FIFO occupancy, 0..8
- iir_ready  in  1  ready output of the downstream IIR
- iir_done  in  1  done pulse of the downstream IIR
- iir_start  out  1  one-cycle session start pulse to the IIR
- params  out  16  coefficient bus to the IIR
- start  out  1  one-cycle sample strobe to the IIR
- din  out  8  sample to the IIR
- busy  out  1  high in every state except IDLE
- issued  out  16  samples issued in the current session; wraps at 0xFFFF->0
- ovf  out  1  sticky push-while-full flag; present only under the macro

Function
REQ-002 SHALL hold 5x16-bit coefficient registers; cfg_we writes cfg_data[cfg_addr] only in IDLE; writes in other states or to indices 5-7 are dropped.
REQ-003 SHALL provide an 8x8 FIFO; a push occurs when s_valid=1 and s_full=0, where s_full is taken from the pre-edge count; a push while full is dropped even if a pop occurs in the same cycle.
REQ-004 SHALL allow a simultaneous push and pop (FIFO not full) and leave s_count unchanged; read/write pointers SHALL wrap modulo 8.
REQ-005 SHALL implement the states IDLE, PARAM, WAIT_RDY, ISSUE and WAIT_ACK.
REQ-006 IDLE: params=a1; on go=1 SHALL go to PARAM with index k=0 and clear issued.
REQ-007 PARAM: SHALL drive params=coef[k] for k=0..4 on 5 consecutive cycles, with iir_start=1 only in the k=0 cycle; after k=4 SHALL go to WAIT_RDY.
REQ-008 WAIT_RDY: when iir_ready=1 and s_count>0, SHALL go to ISSUE; with the FIFO empty it SHALL wait indefinitely.
REQ-009 ISSUE: lasts exactly one cycle, with start=1 and din=FIFO head; SHALL pop the FIFO, increment issued, and go to WAIT_ACK.
REQ-010 din SHALL hold its last issued value until the next ISSUE; start SHALL be 0 outside ISSUE.
REQ-011 WAIT_ACK: SHALL ignore iir_ready=1 and go to WAIT_RDY only after sampling iir_ready=0; this prevents a double issue, because the IIR's ready lags by one cycle.
REQ-012 iir_done=1 in any non-IDLE state SHALL force IDLE on the next edge; this takes priority over all other transitions, and an ISSUE in that cycle still completes its pop.
REQ-013 SHALL ignore go outside IDLE; go held high SHALL start a new session immediately after a return to IDLE.
REQ-014 iir_start, start, din, params and busy SHALL be registered or decoded from registered state only, with no combinational path from any input.

Reset
REQ-015 reset=1 SHALL immediately force: state IDLE, FIFO empty (s_count=0, s_full=0), coefficients 0, params=0, din=0, start=0, iir_start=0, busy=0, issued=0, ovf=0.
REQ-016 Reset mid-session SHALL discard FIFO contents and coefficients; there is no partial recovery.

Configuration
REQ-017 With IIR_FEEDER_OVF_EN defined, port ovf SHALL exist, set on any dropped push, and clear only by reset.
REQ-018 Without IIR_FEEDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-019 Write coefs 0x0100,0x0200,0x0300,0x0400,0x0500, then assert go -> params reads 0x0100..0x0500 on 5 consecutive cycles, with iir_start high only in the first.
REQ-020 Push 3 samples 0x11,0x22,0x33 and hold iir_ready=1 continuously -> exactly one start, with din=0x11, until iir_ready drops low; after three ready low/high cycles issued=3 and din order is 0x11,0x22,0x33.
REQ-021 Push 10 samples back-to-back with no pops -> s_count=8, s_full=1, 2 samples dropped, ovf=1 (macro defined); the later pops return only the first 8 samples.
REQ-022 With the FIFO full, assert push and pop in the same cycle -> push dropped, s_count=7.
REQ-023 Pulse iir_done while in WAIT_ACK -> IDLE and busy=0 on the next cycle; cfg writes accepted again.
REQ-024 Assert reset during PARAM at k=2 -> all outputs at reset values in the same cycle, FIFO empty, coefficients read back 0 on the next session.
